alu_operand_stage: RTL and testbench

//  Registered ALU operand-select stage for the RISC-V integer pipeline.

---
 rtl/alu_operand_stage.sv | 117 +++++++++++
 tb/tb_alu_operand_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand-select stage: resolves rs1/rs2 forwarding, muxes ALU operands A/B and
// registers them behind a valid/ready handshake. Forwarding is built only with ALU_OPERAND_FWD_EN.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         reg_data1,
    input  logic [XLEN-1:0]         reg_data2,
    input  logic [XLEN-1:0]         immediate,
    input  logic [XLEN-1:0]         pc,
    input  logic [1:0]              asel,
    input  logic [1:0]              bsel,
    input  logic                    mem_write,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]      fwd_hit_a,
    input  logic [NUM_FWD-1:0]      fwd_hit_b,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         alu_in1,
    output logic [XLEN-1:0]         alu_in2,
    output logic [XLEN-1:0]         store_data,
    output logic                    mem_write_q
);

    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;

`ifdef ALU_OPERAND_FWD_EN
    logic [XLEN-1:0] fwd_src [NUM_FWD];

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_src
            assign fwd_src[gi] = fwd_data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Scan from the oldest source down so the youngest (lowest index) hit wins.
    always_comb begin
        rs1v = reg_data1;
        rs2v = reg_data2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_hit_a[i]) rs1v = fwd_src[i];
            if (fwd_hit_b[i]) rs2v = fwd_src[i];
        end
    end
`else
    // Without forwarding the hazard unit stalls instead; the forwarding ports are inert.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_data, fwd_hit_a, fwd_hit_b};
    assign rs1v = reg_data1;
    assign rs2v = reg_data2;
`endif

    logic [XLEN-1:0] alu_in1_next;
    logic [XLEN-1:0] alu_in2_next;

    always_comb begin
        alu_in1_next = '0;
        case (asel)
            2'd0:    alu_in1_next = rs1v;
            2'd1:    alu_in1_next = pc;
            default: alu_in1_next = '0;
        endcase
    end

    always_comb begin
        alu_in2_next = '0;
        case (bsel)
            2'd0:    alu_in2_next = rs2v;
            2'd1:    alu_in2_next = immediate;
            2'd2:    alu_in2_next = XLEN'(4);
            default: alu_in2_next = '0;
        endcase
    end

    logic            out_valid_reg;
    logic [XLEN-1:0] alu_in1_reg;
    logic [XLEN-1:0] alu_in2_reg;
    logic [XLEN-1:0] store_data_reg;
    logic            mem_write_reg;
    logic            capture;

    assign in_ready = !out_valid_reg || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            alu_in1_reg    <= '0;
            alu_in2_reg    <= '0;
            store_data_reg <= '0;
            mem_write_reg  <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            out_valid_reg  <= 1'b1;
            alu_in1_reg    <= alu_in1_next;
            alu_in2_reg    <= alu_in2_next;
            store_data_reg <= rs2v;
            mem_write_reg  <= mem_write;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign alu_in1     = alu_in1_reg;
    assign alu_in2     = alu_in2_reg;
    assign store_data  = store_data_reg;
    assign mem_write_q = mem_write_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed operand/handshake cases plus a random stream.
module tb_alu_operand_stage;
    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [XLEN-1:0]         reg_data1 = '0;
    logic [XLEN-1:0]         reg_data2 = '0;
    logic [XLEN-1:0]         immediate = '0;
    logic [XLEN-1:0]         pc = '0;
    logic [1:0]              asel = '0;
    logic [1:0]              bsel = '0;
    logic                    mem_write = 1'b0;
    logic [NUM_FWD*XLEN-1:0] fwd_data = '0;
    logic [NUM_FWD-1:0]      fwd_hit_a = '0;
    logic [NUM_FWD-1:0]      fwd_hit_b = '0;
    logic                    flush = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [XLEN-1:0]         alu_in1;
    logic [XLEN-1:0]         alu_in2;
    logic [XLEN-1:0]         store_data;
    logic                    mem_write_q;

    alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .reg_data1(reg_data1), .reg_data2(reg_data2), .immediate(immediate), .pc(pc),
        .asel(asel), .bsel(bsel), .mem_write(mem_write), .fwd_data(fwd_data),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .store_data(store_data), .mem_write_q(mem_write_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
        logic            mw;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    logic model_valid = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: first hit scanning upward from source 0, else the register value.
    function automatic logic [XLEN-1:0] resolve(input logic [XLEN-1:0] regv,
                                                input logic [NUM_FWD-1:0] hits);
        logic [XLEN-1:0] v;
        logic found;
        v = regv;
        found = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!found && hits[i]) begin
                v = fwd_data[i*XLEN +: XLEN];
                found = 1'b1;
            end
        end
`endif
        return v;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        r1 = resolve(reg_data1, fwd_hit_a);
        r2 = resolve(reg_data2, fwd_hit_b);
        e.a  = (asel == 2'd0) ? r1 : (asel == 2'd1) ? pc : 32'h0;
        e.b  = (bsel == 2'd0) ? r2 : (bsel == 2'd1) ? immediate :
               (bsel == 2'd2) ? 32'd4 : 32'h0;
        e.sd = r2;
        e.mw = mem_write;
        return e;
    endfunction

    task automatic randomize_inputs();
        reg_data1 = $urandom;
        reg_data2 = $urandom;
        immediate = $urandom;
        pc        = $urandom;
        asel      = 2'($urandom_range(0, 3));
        bsel      = 2'($urandom_range(0, 3));
        mem_write = 1'($urandom);
        fwd_data  = {$urandom, $urandom};
        fwd_hit_a = 2'($urandom);
        fwd_hit_b = 2'($urandom);
    endtask

    // One clock of handshake: inputs already driven at the preceding negedge.
    task automatic step(input string tag);
        logic cap;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!model_valid || out_ready));
        cap = in_valid && (!model_valid || out_ready) && !flush;
        if (cap) sb_q.push_back(predict());
        @(posedge clk);
        #1;
        if (flush) model_valid = 1'b0;
        else if (cap) begin
            model_valid = 1'b1;
            held = sb_q.pop_front();
        end else if (out_ready) model_valid = 1'b0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model_valid));
        if (model_valid) begin
            check({tag, ".alu_in1"}, alu_in1, held.a);
            check({tag, ".alu_in2"}, alu_in2, held.b);
            check({tag, ".store_data"}, store_data, held.sd);
            check({tag, ".mem_write_q"}, 32'(mem_write_q), 32'(held.mw));
        end
        $display("%s: in_valid=%0b out_ready=%0b flush=%0b -> out_valid=%0b a=%h b=%h sd=%h mw=%0b",
                 tag, in_valid, out_ready, flush, out_valid, alu_in1, alu_in2, store_data, mem_write_q);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst.async_valid", 32'(out_valid), 32'h0);
        model_valid = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst.out_valid", 32'(out_valid), 32'h0);
            check("rst.alu_in1", alu_in1, 32'h0);
            check("rst.alu_in2", alu_in2, 32'h0);
            check("rst.store_data", store_data, 32'h0);
            check("rst.mem_write_q", 32'(mem_write_q), 32'h0);
            $display("reset: out_valid=%0b a=%h b=%h sd=%h", out_valid, alu_in1, alu_in2, store_data);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
    endtask

    initial begin
        do_reset();

        // Immediate path
        randomize_inputs();
        fwd_hit_a = '0; fwd_hit_b = '0;
        asel = 2'd0; bsel = 2'd1; reg_data1 = 32'h10; immediate = 32'hFFFF_FFFC;
        in_valid = 1'b1; out_ready = 1'b1;
        step("imm");
        check("imm.const_a", alu_in1, 32'h10);
        check("imm.const_b", alu_in2, 32'hFFFF_FFFC);

        // Forward priority on rs2
        randomize_inputs();
        fwd_hit_a = '0; fwd_hit_b = 2'b11;
        fwd_data = {32'h0000_BBBB, 32'h0000_AAAA};
        reg_data2 = 32'h5555_5555; bsel = 2'd0; mem_write = 1'b1;
        step("fwd");
`ifdef ALU_OPERAND_FWD_EN
        check("fwd.const_b", alu_in2, 32'h0000_AAAA);
        check("fwd.const_sd", store_data, 32'h0000_AAAA);
`else
        check("fwd.const_b", alu_in2, 32'h5555_5555);
        check("fwd.const_sd", store_data, 32'h5555_5555);
`endif
        check("fwd.const_mw", 32'(mem_write_q), 32'h1);

        // Stall: capture, hold three cycles under changing inputs, then retire+load
        randomize_inputs();
        out_ready = 1'b1; in_valid = 1'b1;
        step("stall.cap");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            out_ready = 1'b0;
            step("stall.hold");
        end
        randomize_inputs();
        out_ready = 1'b1;
        step("stall.release");

        // Flush while stalled with a new instruction offered
        randomize_inputs();
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1;
        step("flush");
        flush = 1'b0; in_valid = 1'b0;
        step("flush.after");

        // JAL link operands
        randomize_inputs();
        asel = 2'd1; bsel = 2'd2; pc = 32'h0000_0100;
        in_valid = 1'b1; out_ready = 1'b1;
        step("jal");
        check("jal.const_a", alu_in1, 32'h100);
        check("jal.const_b", alu_in2, 32'h4);

        // Reset in the middle of a stall drops the held item
        randomize_inputs();
        step("rst_stall.cap");
        out_ready = 1'b0;
        step("rst_stall.hold");
        do_reset();
        randomize_inputs();
        in_valid = 1'b1;
        step("rst_stall.first");

        // Random stream
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
